// File: rtl/branch_target_predictor_pkg.sv
// branch_target_predictor_pkg: shared branch-type encodings and 2-bit counter constants
package branch_target_predictor_pkg;
  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BGE      = 3'd4,
    BLTU     = 3'd5,
    BGEU     = 3'd6
  } branch_t;
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;
endpackage

// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup, EX resolution and statistics bus of the predictor
interface branch_target_predictor_if;
  import branch_target_predictor_pkg::*;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  branch_t     BranchTypeE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;
  modport master (
    output PCF, PCE, BranchTypeE, BranchE, BranchTargetE, PredTakenE, PredTargetE, StallE,
    input  PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCount, MispredCount
  );
  modport slave (
    input  PCF, PCE, BranchTypeE, BranchE, BranchTargetE, PredTakenE, PredTargetE, StallE,
    output PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  always_comb begin
    ctr_next = taken ? ((ctr == STRONG_T) ? STRONG_T : ctr + 2'd1)
                     : ((ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1);
  end
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit counters, EX training and mispredict redirect
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input logic                     CPU_CLK,
  input logic                     CPU_RST,
  branch_target_predictor_if.slave bus
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [31:0]        branch_count;
  logic [31:0]        mispred_count;
  logic [IDX-1:0]     idx_f;
  logic [IDX-1:0]     idx_e;
  logic               hit_f;
  logic               hit_e;
  logic               upd;
  logic [1:0]         ctr_next;
  assign idx_f = bus.PCF[IDX+1:2];
  assign idx_e = bus.PCE[IDX+1:2];
  assign hit_f = valid[idx_f] && (tag[idx_f] == bus.PCF[31:IDX+2]);
  assign hit_e = valid[idx_e] && (tag[idx_e] == bus.PCE[31:IDX+2]);
  assign upd   = (bus.BranchTypeE != NOBRANCH) && !bus.StallE;
  assign bus.PredTakenF   = hit_f && ctr[idx_f][1];
  assign bus.PredTargetF  = bus.PredTakenF ? target[idx_f] : bus.PCF + 32'd4;
  assign bus.MispredictE  = upd && ((bus.BranchE != bus.PredTakenE) ||
                                    (bus.BranchE && (bus.PredTargetE != bus.BranchTargetE)));
  assign bus.CorrectPCE   = bus.BranchE ? bus.BranchTargetE : bus.PCE + 32'd4;
  assign bus.BranchCount  = branch_count;
  assign bus.MispredCount = mispred_count;
  sat_counter2 u_ctr (
    .ctr      (ctr[idx_e]),
    .taken    (bus.BranchE),
    .ctr_next (ctr_next)
  );
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) begin
      valid         <= '0;
      branch_count  <= '0;
      mispred_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= WEAK_NT;
      end
    end else begin
      if (upd) begin
        valid[idx_e] <= 1'b1;
        tag[idx_e]   <= bus.PCE[31:IDX+2];
        ctr[idx_e]   <= hit_e ? ctr_next : (bus.BranchE ? WEAK_T : WEAK_NT);
        if (bus.BranchE || !hit_e) target[idx_e] <= bus.BranchTargetE;
      end
      if (upd && !(&branch_count)) branch_count <= branch_count + 32'd1;
      if (bus.MispredictE && !(&mispred_count)) mispred_count <= mispred_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed scoreboard bench for the branch target predictor
module tb_branch_target_predictor;
  import branch_target_predictor_pkg::*;
  typedef enum int {S_PT, S_TGT, S_MIS, S_CPC, S_BC, S_MC} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;
  logic CPU_CLK = 1'b0;
  logic CPU_RST;
  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];
  branch_target_predictor_if bus ();
  branch_target_predictor #(.ENTRIES(16)) dut (
    .CPU_CLK (CPU_CLK),
    .CPU_RST (CPU_RST),
    .bus     (bus.slave)
  );
  always #5 CPU_CLK = ~CPU_CLK;
  function automatic logic [31:0] pick(sel_t s);
    return (s == S_PT)  ? {31'd0, bus.PredTakenF} :
           (s == S_TGT) ? bus.PredTargetF :
           (s == S_MIS) ? {31'd0, bus.MispredictE} :
           (s == S_CPC) ? bus.CorrectPCE :
           (s == S_BC)  ? bus.BranchCount : bus.MispredCount;
  endfunction
  task automatic push(input string t, input sel_t s, input logic [31:0] e);
    exp_t x;
    x.tag = t;
    x.sel = s;
    x.exp = e;
    sb.push_back(x);
  endtask
  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = pick(x.sel);
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask
  task automatic cyc();
    @(negedge CPU_CLK);
    drain();
    @(posedge CPU_CLK);
    #1;
  endtask
  task automatic ex(input branch_t ty, input logic tk, input logic [31:0] pce,
                    input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                    input logic st);
    bus.BranchTypeE   = ty;
    bus.BranchE       = tk;
    bus.PCE           = pce;
    bus.BranchTargetE = tgt;
    bus.PredTakenE    = pt;
    bus.PredTargetE   = ptgt;
    bus.StallE        = st;
  endtask
  task automatic idle();
    ex(NOBRANCH, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic look(input string t, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    bus.PCF = pc;
    push({t, "_pt"}, S_PT, {31'd0, pt});
    push({t, "_tgt"}, S_TGT, tgt);
  endtask
  task automatic counts(input string t, input logic [31:0] bc, input logic [31:0] mc);
    push({t, "_bc"}, S_BC, bc);
    push({t, "_mc"}, S_MC, mc);
  endtask
  task automatic resolve(input string t, input logic mis, input logic [31:0] cpc);
    push({t, "_mis"}, S_MIS, {31'd0, mis});
    push({t, "_cpc"}, S_CPC, cpc);
  endtask
  initial begin
    CPU_RST = 1'b0;
    idle();
    look("rst", 32'h40, 1'b0, 32'h44);
    counts("rst", 0, 0);
    cyc();
    cyc();
    CPU_RST = 1'b1;
    look("post_rst", 32'h40, 1'b0, 32'h44);
    counts("post_rst", 0, 0);
    cyc();
    ex(BEQ, 1'b1, 32'h40, 32'h20, 1'b0, 32'h44, 1'b0);
    resolve("train1", 1'b1, 32'h20);
    look("collide", 32'h40, 1'b0, 32'h44);
    cyc();
    idle();
    look("trained", 32'h40, 1'b1, 32'h20);
    counts("trained", 1, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      ex(BEQ, 1'b1, 32'h40, 32'h20, 1'b1, 32'h20, 1'b0);
      resolve("sat_up", 1'b0, 32'h20);
      look("sat_up", 32'h40, 1'b1, 32'h20);
      cyc();
    end
    ex(BEQ, 1'b0, 32'h40, 32'h20, 1'b1, 32'h20, 1'b0);
    resolve("nt1", 1'b1, 32'h44);
    counts("pre_nt1", 4, 1);
    cyc();
    idle();
    look("after_nt1", 32'h40, 1'b1, 32'h20);
    counts("after_nt1", 5, 2);
    cyc();
    ex(BEQ, 1'b0, 32'h40, 32'h20, 1'b1, 32'h20, 1'b0);
    resolve("nt2", 1'b1, 32'h44);
    cyc();
    idle();
    look("after_nt2", 32'h40, 1'b0, 32'h44);
    counts("after_nt2", 6, 3);
    cyc();
    ex(BEQ, 1'b1, 32'h40, 32'h20, 1'b0, 32'h44, 1'b0);
    resolve("retrain", 1'b1, 32'h20);
    cyc();
    idle();
    look("retrained", 32'h40, 1'b1, 32'h20);
    cyc();
    ex(BEQ, 1'b1, 32'h40, 32'h24, 1'b1, 32'h20, 1'b0);
    resolve("tgt_chg", 1'b1, 32'h24);
    cyc();
    idle();
    look("tgt_new", 32'h40, 1'b1, 32'h24);
    counts("tgt_new", 8, 5);
    cyc();
    ex(BNE, 1'b0, 32'h80, 32'h100, 1'b0, 32'h84, 1'b0);
    resolve("alias", 1'b0, 32'h84);
    cyc();
    idle();
    look("alias_40", 32'h40, 1'b0, 32'h44);
    cyc();
    look("alias_80", 32'h80, 1'b0, 32'h84);
    counts("alias", 9, 5);
    cyc();
    for (int i = 0; i < 3; i++) begin
      ex(BNE, 1'b1, 32'h80, 32'h100, 1'b0, 32'h84, 1'b1);
      push("stall_mis", S_MIS, 32'd0);
      look("stall", 32'h80, 1'b0, 32'h84);
      counts("stall", 9, 5);
      cyc();
    end
    ex(BNE, 1'b1, 32'h80, 32'h100, 1'b0, 32'h84, 1'b0);
    resolve("release", 1'b1, 32'h100);
    counts("release_pre", 9, 5);
    cyc();
    idle();
    look("release_hit", 32'h80, 1'b1, 32'h100);
    counts("release", 10, 6);
    cyc();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc();
    CPU_RST = 1'b0;
    ex(BEQ, 1'b1, 32'h40, 32'h60, 1'b0, 32'h44, 1'b0);
    resolve("rst_upd", 1'b1, 32'h60);
    cyc();
    CPU_RST = 1'b1;
    idle();
    look("cleared_80", 32'h80, 1'b0, 32'h84);
    counts("cleared", 0, 0);
    cyc();
    look("cleared_40", 32'h40, 1'b0, 32'h44);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-stage dynamic branch predictor for the RV32 pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It predicts taken/target for the PC being fetched in IF. It is trained from the EX-stage resolution outcome (branch type, actual taken decision, actual target), and it raises the misprediction/redirect request the hazard unit uses to flush IF/ID.

## Interface
- `ENTRIES`, 16: table depth; power of two, 4..256. `IDX = log2(ENTRIES)`.
- `CPU_CLK`  in  1  clock; all state updates on rising edge.
- `CPU_RST`  in  1  synchronous, active-low reset.
- `PCF`  in  32  fetch PC being looked up.
- `PredTakenF`  out  1  prediction for `PCF`; piped down to EX by the pipeline registers.
- `PredTargetF`  out  32  next fetch PC chosen by the predictor; piped down to EX.
- `PCE`  in  32  PC of the instruction in EX.
- `BranchTypeE`  in  3  branch type per shared encoding; `NOBRANCH` = not a branch.
- `BranchE`  in  1  actual taken outcome from the EX branch decision.
- `BranchTargetE`  in  32  actual branch target (`PCE + imm`).
- `PredTakenE`  in  1  `PredTakenF` as carried to EX.
- `PredTargetE`  in  32  `PredTargetF` as carried to EX.
- `StallE`  in  1  EX held this cycle; suppresses training.
- `MispredictE`  out  1  redirect request; flush IF/ID.
- `CorrectPCE`  out  32  PC to refetch when `MispredictE`.
- `BranchCount`  out  32  resolved conditional branches since reset.
- `MispredCount`  out  32  mispredictions since reset.

## Operation
- Entry contents: `valid`, `tag = PC[31:IDX+2]`, `target[31:0]`, `ctr[1:0]`. Index is `PC[IDX+1:2]`.
- Lookup is combinational on `PCF`.
  - `hitF = valid && tag match`.
  - `PredTakenF = hitF && ctr[1]`.
  - `PredTargetF = PredTakenF ? target : PCF + 4`.
- Training enable: `upd = (BranchTypeE != NOBRANCH) && !StallE`.
- Training on `upd`, at index of `PCE`:
  - Tag hit: counter saturates up if `BranchE`, down otherwise; 11 stays 11, 00 stays 00. `target <= BranchTargetE` only when `BranchE`.
  - Miss: allocate and overwrite any prior occupant. Set `valid=1`, tag from `PCE`, `target=BranchTargetE`, `ctr = BranchE ? 2'b10 : 2'b01`.
- Misprediction, combinational:
  - `MispredictE = upd && ((BranchE != PredTakenE) || (BranchE && PredTargetE != BranchTargetE))`.
  - `CorrectPCE = BranchE ? BranchTargetE : PCE + 4`. It is valid whenever `upd`, and don't-care otherwise.
- Statistics:
  - `BranchCount` increments on every `upd`.
  - `MispredCount` increments when `MispredictE`.
  - Both saturate at `32'hFFFF_FFFF`.
- All PC arithmetic is 32-bit modular: `PCF + 4` wraps from `32'hFFFF_FFFC` to 0.

## Timing
- Lookup: 0-cycle, purely combinational from `PCF`.
- Training write: takes effect at the rising edge ending the `upd` cycle, and is visible to lookups from the next cycle.
- Same-cycle lookup and update at the same index: lookup returns the pre-update contents. There is no write-through bypass.
- `StallE` high: no table write and no counter increment. `MispredictE` is forced 0 (`upd` low), so the same EX instruction is counted once when it finally advances.
- Reset (`CPU_RST == 0` at an edge):
  - Every `valid=0`, every `ctr=2'b01`, every `target=0`.
  - `BranchCount=0` and `MispredCount=0`.
  - Reset takes precedence over a concurrent `upd`.
- Outputs during and after reset: `PredTakenF=0`, `PredTargetF=PCF+4`. `MispredictE` follows its equation; the hazard unit ignores it while in reset.
- Reset asserted mid-stream discards all training. There is no partial state.

## Structure
- Shared parameter header supplies:
  - Branch-type encodings, including `NOBRANCH`, `BEQ`..`BGEU`, reused unchanged.
  - Counter constants: `STRONG_NT=2'b00`, `WEAK_NT=2'b01`, `WEAK_T=2'b10`, `STRONG_T=2'b11`.
- One natural sub-module: `sat_counter2`, the combinational 2-bit next-state function (`ctr`, `taken` → `ctr_next`), instantiated once in the update path.
- Table is register arrays (reset requires clearing valid bits); no RAM macro.

## Test plan
- Reset, then `PCF=32'h0000_0040` → `PredTakenF=0`, `PredTargetF=32'h0000_0044`, both counters 0.
- Train: `PCE=32'h40`, `BEQ`, `BranchE=1`, `BranchTargetE=32'h20`, `PredTakenE=0`.
  - Same cycle → `MispredictE=1`, `CorrectPCE=32'h20`.
  - Next cycle, `PCF=32'h40` → `PredTakenF=1`, `PredTargetF=32'h20`, `MispredCount=1`.
- Saturation: same branch taken 3 more times, then not-taken once.
  - Counter goes 10→11→11→11→10; prediction stays taken.
  - Second not-taken → 01, and lookup then predicts not-taken.
- Aliasing with `ENTRIES=16`: train `PCE=32'h40` taken, then `PCE=32'h80` not-taken (same index, different tag).
  - Lookup of `32'h40` → miss, not-taken.
  - Lookup of `32'h80` → hit, ctr=01.
- Stall and collision:
  - `upd` conditions with `StallE=1` for 3 cycles → no counter change, `MispredictE=0`. Release → exactly one increment of `BranchCount`.
  - Update and lookup of the same PC in one cycle → lookup shows old entry.
- Target change and reset: a hit predicted taken to `32'h20` now resolves to `32'h24` → `MispredictE=1` and target is rewritten. Assert `CPU_RST=0` during a concurrent `upd` → table and counters cleared, no write.
